// File: rtl/tcm_boot_loader.sv
// tcm_boot_loader
// ---------------
// Stream-fed image loader placed in front of tcm_mem's data port. A 4-byte
// little-endian length header is followed by LEN payload bytes. The payload is
// packed into 32-bit little-endian word writes starting at BASE_ADDR. The core
// is held in reset until every issued write has been acknowledged.
//
// Optional feature: define TCM_BOOT_LOADER_CHECKSUM_EN to expect a 4-byte
// little-endian trailer after the payload. The trailer holds the 32-bit
// wrap-around sum of all payload bytes. A mismatching trailer ends in ERR.
//
// Ports:
//   clk            clock
//   rst            synchronous, active-low reset
//   in_valid_i     stream byte valid
//   in_data_i      stream byte
//   in_ready_o     loader accepts the byte this cycle
//   mem_addr_o     word-aligned write address
//   mem_data_wr_o  write data
//   mem_wr_o       byte strobes; nonzero means a request is presented
//   mem_accept_i   request taken this cycle
//   mem_ack_i      write completion
//   mem_error_i    marks the accompanying mem_ack_i as failed
//   core_rst_o     active-high reset to the core
//   done_o         image loaded and core released
//   err_o          load failed; sticky until reset
module tcm_boot_loader #(
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
  parameter int unsigned MEM_SIZE        = 131072,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_wr_o,
  output logic [3:0]  mem_wr_o,
  input  logic        mem_accept_i,
  input  logic        mem_ack_i,
  input  logic        mem_error_i,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_HDR, S_DATA, S_WRITE, S_CSUM, S_DRAIN, S_DONE, S_ERR
  } state_e;

  localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);
  localparam logic [31:0] MAX_LEN = 32'(MEM_SIZE);

  state_e      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;   // header / trailer byte position
  logic [31:0] byte_cnt_q, byte_cnt_d; // payload bytes accepted so far
  logic [29:0] word_idx_q, word_idx_d;
  logic [31:0] buf_q, buf_d;
  logic [3:0]  strb_q, strb_d;
  logic [3:0]  outst_q, outst_d;
  logic        ack_ok;
  logic        accept;
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic [31:0] csum_q, csum_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_HDR;
      len_q      <= '0;
      hdr_cnt_q  <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      buf_q      <= '0;
      strb_q     <= '0;
      outst_q    <= '0;
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hdr_cnt_q  <= hdr_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      buf_q      <= buf_d;
      strb_q     <= strb_d;
      outst_q    <= outst_d;
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    len_d         = len_q;
    hdr_cnt_d     = hdr_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    word_idx_d    = word_idx_q;
    buf_d         = buf_q;
    strb_d        = strb_q;
    outst_d       = outst_q;
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
    sum_d         = sum_q;
    csum_d        = csum_q;
`endif
    accept        = 1'b0;
    in_ready_o    = 1'b0;
    mem_wr_o      = '0;
    mem_addr_o    = '0;
    mem_data_wr_o = '0;
    core_rst_o    = 1'b1;
    done_o        = 1'b0;
    err_o         = 1'b0;

    // Acks with nothing outstanding belong to an aborted load and are dropped.
    ack_ok = mem_ack_i && (outst_q != '0);

    case (state_q)
      S_HDR: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          len_d     = {in_data_i, len_q[31:8]};
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            if (len_d > MAX_LEN)    state_d = S_ERR;
            else if (len_d == '0)   state_d = S_DRAIN;
            else                    state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          buf_d[{byte_cnt_q[1:0], 3'b000} +: 8] = in_data_i;
          strb_d[byte_cnt_q[1:0]]               = 1'b1;
          byte_cnt_d                            = byte_cnt_q + 32'd1;
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
          sum_d = sum_q + {24'b0, in_data_i};
`endif
          if (byte_cnt_q[1:0] == 2'd3 || byte_cnt_d == len_q) state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        // Address and data stay on the bus while the request is throttled;
        // only the strobes are withheld.
        mem_addr_o    = BASE_ADDR + {word_idx_q, 2'b00};
        mem_data_wr_o = buf_q;
        if (outst_q != MAX_OUT) begin
          mem_wr_o = strb_q;
          if (mem_accept_i) begin
            accept     = 1'b1;
            buf_d      = '0;
            strb_d     = '0;
            word_idx_d = word_idx_q + 30'd1;
            if (byte_cnt_q != len_q) state_d = S_DATA;
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
            else                     state_d = S_CSUM;
`else
            else                     state_d = S_DRAIN;
`endif
          end
        end
      end

`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          csum_d    = {in_data_i, csum_q[31:8]};
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) state_d = (csum_d == sum_q) ? S_DRAIN : S_ERR;
        end
      end
`endif

      S_DRAIN: begin
        // Leave as soon as the last outstanding ack is being sampled.
        if (outst_q == {3'b000, ack_ok}) state_d = S_DONE;
      end

      S_DONE: begin
        core_rst_o = 1'b0;
        done_o     = 1'b1;
      end

      S_ERR: begin
        err_o = 1'b1;
      end

      default: state_d = S_ERR;
    endcase

    if (ack_ok && mem_error_i) state_d = S_ERR;

    case ({accept, ack_ok})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase

    // No bytes are taken while reset is held, even though the state reads HDR.
    if (!rst) in_ready_o = 1'b0;
  end

endmodule

// File: tb/tb_tcm_boot_loader.sv
// Self-checking bench for tcm_boot_loader. Table-driven image loads with
// random payloads, stream gaps and accept stalls are compared against a
// word-packing model; hand-written sequences cover fixed images, held
// requests, error acks, mid-load reset and a single-outstanding instance.
`timescale 1ns/1ps
module tb_tcm_boot_loader;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          MAXO = 4;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;
  typedef struct {
    int len;
    int lat;
    int acc_pct;
    bit gaps;
    bit exp_done;
    bit exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: default parameters.
  logic        rst, in_valid_i, in_ready_o;
  logic [7:0]  in_data_i;
  logic [31:0] mem_addr_o, mem_data_wr_o;
  logic [3:0]  mem_wr_o;
  logic        mem_accept_i, mem_ack_i, mem_error_i;
  logic        core_rst_o, done_o, err_o;

  tcm_boot_loader #(.BASE_ADDR(BASE), .MEM_SIZE(131072), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_wr_o(mem_wr_o),
    .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i), .mem_error_i(mem_error_i),
    .core_rst_o(core_rst_o), .done_o(done_o), .err_o(err_o)
  );

  // Second instance: one outstanding write, 16-byte memory.
  logic        u_rst, u_in_valid, u_in_ready;
  logic [7:0]  u_in_data;
  logic [31:0] u_addr, u_data;
  logic [3:0]  u_wr;
  logic        u_accept, u_ack, u_error;
  logic        u_core_rst, u_done, u_err;

  tcm_boot_loader #(.BASE_ADDR(BASE), .MEM_SIZE(16), .MAX_OUTSTANDING(1)) dut_one (
    .clk(clk), .rst(u_rst),
    .in_valid_i(u_in_valid), .in_data_i(u_in_data), .in_ready_o(u_in_ready),
    .mem_addr_o(u_addr), .mem_data_wr_o(u_data), .mem_wr_o(u_wr),
    .mem_accept_i(u_accept), .mem_ack_i(u_ack), .mem_error_i(u_error),
    .core_rst_o(u_core_rst), .done_o(u_done), .err_o(u_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Environment state for the main instance.
  bq_t  s_bytes;
  int   s_ptr;
  bit   s_ready_q;
  bit   gaps;
  int   ack_lat, acc_pct, stall_first, err_ack_idx, ack_cnt;
  int   cyc, last_ack_cyc, done_cyc;
  int   ack_due[$];
  wr_t  got_q[$];
  bit   req_prev;
  wr_t  req_prev_v;
  int   stab_bad, stall_ready_bad, tb_out, ovf_bad;

  function automatic bq_t rand_payload(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  function automatic bq_t build_stream(input logic [31:0] len_hdr, input bq_t pay, input bit bad_sum);
    bq_t s;
    logic [31:0] sum;
    sum = '0;
    for (int i = 0; i < 4; i++) s.push_back(len_hdr[8*i +: 8]);
    foreach (pay[i]) begin
      s.push_back(pay[i]);
      sum += {24'b0, pay[i]};
    end
    if (bad_sum) sum = sum + 32'd1;
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
    for (int i = 0; i < 4; i++) s.push_back(sum[8*i +: 8]);
`endif
    return s;
  endfunction

  // One clock of the main environment: at each falling edge account for what
  // the previous rising edge took, then drive the next stream byte and the
  // memory responder (accept policy plus delayed acks).
  task automatic tick();
    wr_t cur;
    bit  acc;
    @(negedge clk);
    cyc++;
    if (in_valid_i && s_ready_q) s_ptr++;
    cur.addr = mem_addr_o;
    cur.data = mem_data_wr_o;
    cur.strb = mem_wr_o;
    if (req_prev && cur != req_prev_v) stab_bad++;
    if (mem_wr_o != '0 && tb_out >= MAXO) ovf_bad++;

    s_ready_q = in_ready_o;
    if (s_ptr < s_bytes.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
      in_valid_i = 1'b1;
      in_data_i  = s_bytes[s_ptr];
    end else begin
      in_valid_i = 1'b0;
      in_data_i  = '0;
    end

    mem_ack_i   = 1'b0;
    mem_error_i = 1'b0;
    if (ack_due.size() != 0 && ack_due[0] <= cyc) begin
      void'(ack_due.pop_front());
      mem_ack_i    = 1'b1;
      mem_error_i  = (ack_cnt == err_ack_idx);
      ack_cnt++;
      last_ack_cyc = cyc;
      if (tb_out > 0) tb_out--;
    end

    acc = 1'b0;
    if (mem_wr_o != '0) begin
      if (stall_first > 0) begin
        stall_first--;
        if (in_ready_o) stall_ready_bad++;
      end else begin
        acc = ($urandom_range(0, 99) < acc_pct);
      end
      if (acc) begin
        got_q.push_back(cur);
        ack_due.push_back(cyc + ack_lat);
        tb_out++;
      end
    end
    mem_accept_i = acc;
    req_prev     = (mem_wr_o != '0) && !acc;
    req_prev_v   = cur;
  endtask

  task automatic do_reset(input bit chk, input string name);
    s_bytes.delete();
    s_ptr = 0;
    ack_due.delete();
    rst = 1'b0;
    tick();
    tick();
    if (chk) begin
      check({name, " in_ready_o"},    in_ready_o,    1'b0);
      check({name, " mem_wr_o"},      mem_wr_o,      4'b0);
      check({name, " mem_addr_o"},    mem_addr_o,    32'h0);
      check({name, " mem_data_wr_o"}, mem_data_wr_o, 32'h0);
      check({name, " core_rst_o"},    core_rst_o,    1'b1);
      check({name, " done_o"},        done_o,        1'b0);
      check({name, " err_o"},         err_o,         1'b0);
    end
    rst = 1'b1;
    got_q.delete();
    req_prev = 1'b0;
    stall_first = 0; err_ack_idx = -1; ack_cnt = 0; last_ack_cyc = -1;
    stab_bad = 0; stall_ready_bad = 0; tb_out = 0; ovf_bad = 0;
  endtask

  task automatic run_load(input string name, input logic [31:0] len_hdr, input bq_t pay,
                          input bit bad_sum, input int budget);
    int n;
    s_bytes = build_stream(len_hdr, pay, bad_sum);
    s_ptr   = 0;
    n       = 0;
    while (!(done_o || err_o) && n < budget) begin
      tick();
      n++;
    end
    done_cyc = cyc;
    check({name, " ends within budget"}, 64'(n < budget), 64'd1);
    for (int i = 0; i < 4; i++) tick();
  endtask

  // Reference packing: word w holds payload bytes 4w..4w+3, lane k = byte 4w+k.
  task automatic verify_writes(input string name, input bq_t pay);
    int nw;
    nw = (pay.size() + 3) / 4;
    check({name, " write count"}, got_q.size(), nw);
    for (int w = 0; w < nw && w < got_q.size(); w++) begin
      logic [31:0] d;
      logic [3:0]  s;
      d = '0;
      s = '0;
      for (int k = 0; k < 4; k++) begin
        if (4*w + k < pay.size()) begin
          d[8*k +: 8] = pay[4*w + k];
          s[k]        = 1'b1;
        end
      end
      check($sformatf("%s w%0d addr", name, w), got_q[w].addr, BASE + 32'(4*w));
      check($sformatf("%s w%0d data", name, w), got_q[w].data, d);
      check($sformatf("%s w%0d strb", name, w), got_q[w].strb, s);
    end
  endtask

  task automatic check_done_latency(input string name);
`ifndef TCM_BOOT_LOADER_CHECKSUM_EN
    check({name, " core release one cycle after last ack"}, done_cyc, last_ack_cyc + 1);
`else
    check({name, " core released after last ack"}, 64'(done_cyc > last_ack_cyc), 64'd1);
`endif
  endtask

  // Hand sequence on the single-outstanding instance: every request must wait
  // for the previous write's ack, acks arrive three cycles after accept.
  task automatic run_one(input string name, input int len, input bit exp_err);
    bq_t s, pay;
    int  ptr, outst, viol, nwr, c, n;
    bit  rdy;
    int  due[$];
    pay = exp_err ? rand_payload(0) : rand_payload(len);
    s   = build_stream(32'(len), pay, 1'b0);
    u_in_valid = 1'b0; u_accept = 1'b0; u_ack = 1'b0;
    u_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    u_rst = 1'b1;
    ptr = 0; outst = 0; viol = 0; nwr = 0; c = 0; n = 0; rdy = 1'b0;
    while (!(u_done || u_err) && n < 800) begin
      @(negedge clk);
      c++;
      n++;
      if (u_in_valid && rdy) ptr++;
      rdy = u_in_ready;
      if (ptr < s.size()) begin
        u_in_valid = 1'b1;
        u_in_data  = s[ptr];
      end else begin
        u_in_valid = 1'b0;
        u_in_data  = '0;
      end
      if (u_wr != '0 && outst != 0) viol++;
      u_ack = 1'b0;
      if (due.size() != 0 && due[0] <= c) begin
        void'(due.pop_front());
        u_ack = 1'b1;
        outst--;
      end
      u_accept = (u_wr != '0);
      if (u_accept) begin
        nwr++;
        outst++;
        due.push_back(c + 3);
      end
    end
    u_in_valid = 1'b0; u_accept = 1'b0; u_ack = 1'b0;
    check({name, " ends within budget"}, 64'(n < 800), 64'd1);
    check({name, " request while one outstanding"}, viol, 0);
    check({name, " write count"}, nwr, exp_err ? 0 : (len + 3) / 4);
    check({name, " done_o"},     u_done,     !exp_err);
    check({name, " err_o"},      u_err,      exp_err);
    check({name, " core_rst_o"}, u_core_rst, exp_err);
  endtask

  initial begin
    vec_t vecs[7];
    bq_t  pay;
    bq_t  t1;
    string nm;

    rst = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
    mem_accept_i = 1'b0; mem_ack_i = 1'b0; mem_error_i = 1'b0;
    u_rst = 1'b0; u_in_valid = 1'b0; u_in_data = '0;
    u_accept = 1'b0; u_ack = 1'b0; u_error = 1'b0;
    cyc = 0; s_ready_q = 1'b0; gaps = 1'b0; ack_lat = 1; acc_pct = 100;

    vecs[0] = '{len: 8,      lat: 5,  acc_pct: 100, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{len: 6,      lat: 1,  acc_pct: 100, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{len: 1,      lat: 2,  acc_pct: 50,  gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{len: 0,      lat: 1,  acc_pct: 100, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{len: 131073, lat: 1,  acc_pct: 100, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[5] = '{len: 37,     lat: 3,  acc_pct: 70,  gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[6] = '{len: 40,     lat: 24, acc_pct: 100, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};

    do_reset(1'b1, "reset");

    // Table-driven loads.
    for (int i = 0; i < 7; i++) begin
      nm      = $sformatf("vec%0d", i);
      do_reset(1'b0, nm);
      ack_lat = vecs[i].lat;
      acc_pct = vecs[i].acc_pct;
      gaps    = vecs[i].gaps;
      pay     = rand_payload(vecs[i].exp_err ? 0 : vecs[i].len);
      run_load(nm, 32'(vecs[i].len), pay, 1'b0, 300 + 20 * pay.size());
      check({nm, " done_o"},     done_o,     vecs[i].exp_done);
      check({nm, " err_o"},      err_o,      vecs[i].exp_err);
      check({nm, " core_rst_o"}, core_rst_o, !vecs[i].exp_done);
      check({nm, " outstanding limit"}, ovf_bad, 0);
      verify_writes(nm, pay);
      if (vecs[i].exp_done && pay.size() != 0) check_done_latency(nm);
    end

    // Fixed two-word image with known packed words.
    do_reset(1'b0, "fixed");
    ack_lat = 1; acc_pct = 100; gaps = 1'b0;
    t1 = '{8'h13, 8'h05, 8'h70, 8'h00, 8'h93, 8'h05, 8'h90, 8'h00};
    run_load("fixed", 32'd8, t1, 1'b0, 400);
    verify_writes("fixed", t1);
    if (got_q.size() == 2) begin
      check("fixed word0", got_q[0].data, 32'h0070_0513);
      check("fixed word1", got_q[1].data, 32'h0090_0593);
    end
    check("fixed done_o", done_o, 1'b1);
    check("fixed core_rst_o", core_rst_o, 1'b0);
    check_done_latency("fixed");

    // First request refused for five cycles: it must be held unchanged.
    do_reset(1'b0, "stall");
    stall_first = 5;
    pay = rand_payload(8);
    run_load("stall", 32'd8, pay, 1'b0, 400);
    check("stall request stable", stab_bad, 0);
    check("stall in_ready_o low", stall_ready_bad, 0);
    check("stall applied", stall_first, 0);
    check("stall done_o", done_o, 1'b1);
    verify_writes("stall", pay);

    // Failed ack on the first write.
    do_reset(1'b0, "errack");
    err_ack_idx = 0;
    pay = rand_payload(8);
    run_load("errack", 32'd8, pay, 1'b0, 400);
    check("errack err_o", err_o, 1'b1);
    check("errack done_o", done_o, 1'b0);
    check("errack core_rst_o", core_rst_o, 1'b1);
    check("errack in_ready_o", in_ready_o, 1'b0);
    check("errack mem_wr_o", mem_wr_o, 4'b0);

    // Reset in the middle of the payload, a stale ack, then a fresh image.
    do_reset(1'b0, "midrst");
    s_bytes = build_stream(32'd16, rand_payload(16), 1'b0);
    s_ptr = 0;
    for (int i = 0; i < 12; i++) tick();
    check("midrst writes before reset", got_q.size(), 1);
    check("midrst done_o before reset", done_o, 1'b0);
    do_reset(1'b1, "midrst reset");
    ack_due.push_back(cyc + 1);
    tick();
    tick();
    pay = rand_payload(4);
    run_load("midrst reload", 32'd4, pay, 1'b0, 400);
    check("midrst reload done_o", done_o, 1'b1);
    verify_writes("midrst reload", pay);

`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
    do_reset(1'b0, "badsum");
    pay = rand_payload(4);
    run_load("badsum", 32'd4, pay, 1'b1, 400);
    check("badsum err_o", err_o, 1'b1);
    check("badsum core_rst_o", core_rst_o, 1'b1);
`endif

    // Single-outstanding instance; 16 is its size limit, 17 exceeds it.
    run_one("one16", 16, 1'b0);
    run_one("one17", 17, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
